// File: rtl/bit_clock_recovery_ch.sv
// bit_clock_recovery_ch
//   Recovers a bit clock from an asynchronous serial input on the 200 MHz base
//   clock. The bit period is estimated as the shortest valid edge-to-edge
//   interval. The estimate relaxes upward slowly while edges stay at or above
//   it. A phase counter is realigned on every valid edge and drives the
//   mid-bit sample strobe and the recovered clock. A SEARCH/LOCKED state
//   machine reports lock. Loss of signal returns the block to its initial
//   period.
//
// Ports
//   clk_200M   in   base clock
//   rst_n      in   asynchronous active-low reset
//   signal     in   asynchronous serial input
//   clk_rec    out  recovered bit clock, rises at mid-bit
//   sample_stb out  one-cycle mid-bit strobe, coincident with clk_rec rise
//   rec_data   out  signal value captured at sample_stb
//   period     out  current bit-period estimate in base-clock cycles
//   locked     out  high while in LOCKED
module bit_clock_recovery_ch #(
  parameter int CNT_W       = 16,
  parameter int INIT_PERIOD = 801,
  parameter int MIN_PERIOD  = 4,
  parameter int RELAX_EDGES = 15,
  parameter int LOCK_EDGES  = 8,
  parameter int LOS_BITS    = 16
) (
  input  logic             clk_200M,
  input  logic             rst_n,
  input  logic             signal,
  output logic             clk_rec,
  output logic             sample_stb,
  output logic             rec_data,
  output logic [CNT_W-1:0] period,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] INIT_P  = CNT_W'(INIT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RELAX_N = CNT_W'(RELAX_EDGES);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_EDGES);
  localparam logic [CNT_W-1:0] LOS_N   = CNT_W'(LOS_BITS);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             sig_p0, sig_s, sig_d;
  logic [CNT_W-1:0] intv, ph, stable_cnt, bit_cnt;
  state_t           state, state_nxt;
  logic             locked_nxt;

  logic             sig_edge, vld_edge, shorter, relax, rate_jump, los;
  logic             ph_wrap, ph_half;
  logic [CNT_W-1:0] stable_inc;

  // Stage p0 -> sig_s -> sig_d: two-flop synchroniser plus edge delay
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      sig_p0 <= 1'b0;
      sig_s  <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sig_p0 <= signal;
      sig_s  <= sig_p0;
      sig_d  <= sig_s;
    end
  end

  // Edges closer than MIN_PERIOD to the last valid edge are glitches and are
  // invisible to every counter; intv is not cleared by them either.
  assign sig_edge   = sig_s ^ sig_d;
  assign vld_edge   = sig_edge && (intv >= MIN_P);
  assign shorter    = intv < period;
  assign stable_inc = stable_cnt + 1'b1;
  assign relax      = vld_edge && !shorter && (stable_inc == RELAX_N);
  assign rate_jump  = vld_edge && (intv < (period - (period >> 2)));
  assign los        = (bit_cnt == LOS_N);
  // >= also catches a phase left beyond a freshly shortened period
  assign ph_wrap    = (ph >= period - 1'b1);
  assign ph_half    = (ph == (period >> 1));

  // intv restarts at 1 so that it holds the exact cycle distance at the
  // next edge (edges N cycles apart read intv == N).
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      intv <= '0;
    end else if (vld_edge) begin
      intv <= CNT_W'(1);
    end else begin
      intv <= sat_inc(intv);
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      period     <= INIT_P;
      stable_cnt <= '0;
    end else if (los) begin
      period     <= INIT_P;
      stable_cnt <= '0;
    end else if (vld_edge) begin
      if (shorter) begin
        period     <= intv;
        stable_cnt <= '0;
      end else if (relax) begin
        period     <= sat_inc(period);
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_inc;
      end
    end
  end

  // Phase counter, wrap counter and mid-bit outputs; a valid edge beats a wrap
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      ph         <= '0;
      bit_cnt    <= '0;
      sample_stb <= 1'b0;
      rec_data   <= 1'b0;
      clk_rec    <= 1'b0;
    end else begin
      if (vld_edge || ph_wrap) begin
        ph <= '0;
      end else begin
        ph <= ph + 1'b1;
      end

      if (los || vld_edge) begin
        bit_cnt <= '0;
      end else if (ph_wrap) begin
        bit_cnt <= sat_inc(bit_cnt);
      end

      sample_stb <= ph_half;
      if (ph_half) begin
        rec_data <= sig_s;
        clk_rec  <= 1'b1;
      end else if (vld_edge || ph_wrap) begin
        clk_rec  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      locked <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (!los && !(vld_edge && shorter) && (stable_cnt >= LOCK_N))
                state_nxt = LOCKED;
      LOCKED: if (los || rate_jump)
                state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // locked is registered from the next state so it tracks state exactly
  always_comb begin
    locked_nxt = (state_nxt == LOCKED);
  end

endmodule

// File: tb/tb_bit_clock_recovery_ch.sv
`timescale 1ns/1ps
module tb_bit_clock_recovery_ch;

  localparam int CNT_W = 16;

  logic             clk_200M = 1'b0;
  logic             rst_n    = 1'b0;
  logic             signal   = 1'b0;
  logic             clk_rec, sample_stb, rec_data, locked;
  logic [CNT_W-1:0] period;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0, stb_last = 0, stb_gap = 0, stb_clk_bad = 0, tgl_cyc = 0;
  logic        exp_bit;

  bit_clock_recovery_ch #(
    .CNT_W(16), .INIT_PERIOD(801), .MIN_PERIOD(4),
    .RELAX_EDGES(15), .LOCK_EDGES(8), .LOS_BITS(16)
  ) dut (
    .clk_200M   (clk_200M),
    .rst_n      (rst_n),
    .signal     (signal),
    .clk_rec    (clk_rec),
    .sample_stb (sample_stb),
    .rec_data   (rec_data),
    .period     (period),
    .locked     (locked)
  );

  always #2.5 clk_200M = ~clk_200M;

  always @(posedge clk_200M) cyc <= cyc + 1;

  // Strobe bookkeeping, sampled on the falling edge
  always @(negedge clk_200M) begin
    if (sample_stb) begin
      stb_gap  = cyc - stb_last;
      stb_last = cyc;
      if (!clk_rec) stb_clk_bad = stb_clk_bad + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_200M);
    #1;
  endtask

  // Toggle the line n times, holding gap cycles after each toggle
  task automatic send_toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      signal  = ~signal;
      tgl_cyc = cyc;
      tick(gap);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (clk_rec !== 1'b0) begin n_bad++; $display("FAIL reset_clk_rec: got %b want 0", clk_rec); end
    n_cmp++; if (sample_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", sample_stb); end
    n_cmp++; if (rec_data !== 1'b0) begin n_bad++; $display("FAIL reset_rec_data: got %b want 0", rec_data); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (period !== 16'd801) begin n_bad++; $display("FAIL reset_period: got %0d want 801", period); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    tick(1000);
    // First edge sees a long interval, second sets period to 100
    send_toggles(2, 100);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL lock_period: got %0d want 100", period); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early0: got %b want 0", locked); end
    send_toggles(7, 100);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_after7: got %b want 0", locked); end
    send_toggles(1, 100);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after8: got %b want 1", locked); end
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL lock_period2: got %0d want 100", period); end
  endtask

  // Strobe lands 3 (sync) + 50 (half period) + 1 (output register) cycles after a toggle
  task automatic test_sampling;
    send_toggles(1, 100);
    n_cmp++; if ((stb_last - tgl_cyc) !== 54) begin n_bad++; $display("FAIL samp_offset1: got %0d want 54", stb_last - tgl_cyc); end
    n_cmp++; if (rec_data !== 1'b1) begin n_bad++; $display("FAIL samp_data1: got %b want 1", rec_data); end
    send_toggles(1, 100);
    n_cmp++; if (stb_gap !== 100) begin n_bad++; $display("FAIL samp_gap: got %0d want 100", stb_gap); end
    n_cmp++; if ((stb_last - tgl_cyc) !== 54) begin n_bad++; $display("FAIL samp_offset2: got %0d want 54", stb_last - tgl_cyc); end
    n_cmp++; if (rec_data !== 1'b0) begin n_bad++; $display("FAIL samp_data0: got %b want 0", rec_data); end
    n_cmp++; if (stb_clk_bad !== 0) begin n_bad++; $display("FAIL samp_stb_vs_clk: got %0d want 0", stb_clk_bad); end
  endtask

  // Stable count is 10 here; five more edges reach 15 and relax to 101
  task automatic test_relax_locked;
    send_toggles(5, 100);
    n_cmp++; if (period !== 16'd101) begin n_bad++; $display("FAIL relaxl_101: got %0d want 101", period); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relaxl_locked: got %b want 1", locked); end
    send_toggles(1, 100);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL relaxl_back100: got %0d want 100", period); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relaxl_locked2: got %b want 1", locked); end
  endtask

  // Ringing: after a real transition the line bounces back for 2 cycles.
  // Those edges fall 1 and 3 cycles after the valid edge and must be ignored.
  task automatic test_glitch;
    signal  = ~signal;
    tgl_cyc = cyc;
    tick(1);
    signal = ~signal;
    tick(2);
    signal = ~signal;
    exp_bit = signal;
    tick(97);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL glitch_period: got %0d want 100", period); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL glitch_locked: got %b want 1", locked); end
    n_cmp++; if ((stb_last - tgl_cyc) !== 54) begin n_bad++; $display("FAIL glitch_offset: got %0d want 54", stb_last - tgl_cyc); end
    n_cmp++; if (stb_gap !== 100) begin n_bad++; $display("FAIL glitch_gap: got %0d want 100", stb_gap); end
    n_cmp++; if (rec_data !== exp_bit) begin n_bad++; $display("FAIL glitch_data: got %b want %b", rec_data, exp_bit); end
    send_toggles(1, 100);
    n_cmp++; if (stb_gap !== 100) begin n_bad++; $display("FAIL glitch_gap2: got %0d want 100", stb_gap); end
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL glitch_period2: got %0d want 100", period); end
  endtask

  // 16 wraps of 100 cycles after the last edge (about cycle 1604) trigger LOS
  task automatic test_los;
    tick(1400);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL los_still_locked: got %b want 1", locked); end
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL los_still_100: got %0d want 100", period); end
    tick(200);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL los_unlocked: got %b want 0", locked); end
    n_cmp++; if (period !== 16'd801) begin n_bad++; $display("FAIL los_period: got %0d want 801", period); end
    tick(2500);
    n_cmp++; if (stb_gap !== 801) begin n_bad++; $display("FAIL los_stb_gap: got %0d want 801", stb_gap); end
    n_cmp++; if (stb_clk_bad !== 0) begin n_bad++; $display("FAIL los_stb_vs_clk: got %0d want 0", stb_clk_bad); end
  endtask

  task automatic test_rate_jump;
    send_toggles(2, 100);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL jump_relock_period: got %0d want 100", period); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL jump_relock_search: got %b want 0", locked); end
    send_toggles(8, 100);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL jump_relocked: got %b want 1", locked); end
    // This toggle still closes a 100-cycle interval; the next closes a 40-cycle one
    send_toggles(1, 40);
    send_toggles(1, 40);
    n_cmp++; if (period !== 16'd40) begin n_bad++; $display("FAIL jump_period: got %0d want 40", period); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL jump_unlock: got %b want 0", locked); end
    send_toggles(7, 40);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL jump_after7: got %b want 0", locked); end
    send_toggles(1, 40);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL jump_after8: got %b want 1", locked); end
    n_cmp++; if (stb_gap !== 40) begin n_bad++; $display("FAIL jump_stb_gap: got %0d want 40", stb_gap); end
  endtask

  // Mid-bit, clk_rec is high (stb fired at toggle+24); reset must clear it at once
  task automatic test_reset_midstream;
    signal  = ~signal;
    exp_bit = signal;
    tick(30);
    n_cmp++; if (clk_rec !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_clk: got %b want 1", clk_rec); end
    n_cmp++; if (rec_data !== exp_bit) begin n_bad++; $display("FAIL mrst_pre_data: got %b want %b", rec_data, exp_bit); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (clk_rec !== 1'b0) begin n_bad++; $display("FAIL mrst_clk_rec: got %b want 0", clk_rec); end
    n_cmp++; if (sample_stb !== 1'b0) begin n_bad++; $display("FAIL mrst_stb: got %b want 0", sample_stb); end
    n_cmp++; if (rec_data !== 1'b0) begin n_bad++; $display("FAIL mrst_rec_data: got %b want 0", rec_data); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mrst_locked: got %b want 0", locked); end
    n_cmp++; if (period !== 16'd801) begin n_bad++; $display("FAIL mrst_period: got %0d want 801", period); end
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_relax;
    tick(1000);
    send_toggles(1, 100);
    send_toggles(1, 200);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL relax_start: got %0d want 100", period); end
    send_toggles(14, 200);
    n_cmp++; if (period !== 16'd100) begin n_bad++; $display("FAIL relax_14: got %0d want 100", period); end
    send_toggles(1, 200);
    n_cmp++; if (period !== 16'd101) begin n_bad++; $display("FAIL relax_15: got %0d want 101", period); end
    send_toggles(14, 200);
    n_cmp++; if (period !== 16'd101) begin n_bad++; $display("FAIL relax_29: got %0d want 101", period); end
    send_toggles(1, 200);
    n_cmp++; if (period !== 16'd102) begin n_bad++; $display("FAIL relax_30: got %0d want 102", period); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relax_locked: got %b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_sampling();
    test_relax_locked();
    test_glitch();
    test_los();
    test_rate_jump();
    test_reset_midstream();
    test_relax();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
